spi_ram_ctrl: RTL and testbench



---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_ram_array.sv | 31 +++
 rtl/spi_ram_ctrl.sv | 113 +++++++++++
 tb/tb_spi_ram_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI RAM controller: frame widths and command codes.
package spi_pkg;
   localparam int FRAME_W = 10;
   localparam int DATA_W  = 8;

   typedef enum logic [1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } cmd_e;
endpackage

// File: rtl/spi_ram_array.sv
// Single-port byte memory with a registered read port; contents are never reset.
module spi_ram_array
   import spi_pkg::*;
#(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 i_we,
   input  logic                 i_re,
   input  logic [ADDR_SIZE-1:0] i_addr,
   input  logic [DATA_W-1:0]    i_wdata,
   output logic [DATA_W-1:0]    o_rdata
);

   logic [DATA_W-1:0] r_mem [MEM_DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // Write port and read register share one address; the read register holds between reads.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Decodes 10-bit SPI frames into address/data commands against an internal byte RAM
// and returns read bytes on a parallel tx port.
module spi_ram_ctrl
   import spi_pkg::*;
#(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [FRAME_W-1:0] rx_data,
   input  logic               rx_valid,
   output logic [DATA_W-1:0]  tx_data,
   output logic               tx_valid,
   output logic               cmd_err
);

   logic [ADDR_SIZE-1:0] r_wr_ptr;
   logic [ADDR_SIZE-1:0] r_rd_ptr;
   logic                 r_wr_ok;
   logic                 r_rd_ok;
   logic                 r_tx_valid;
   logic                 r_cmd_err;
   logic                 r_tx_clr;

   cmd_e                 w_cmd;
   logic                 w_we;
   logic                 w_re;
   logic                 w_err;
   logic                 w_set_wr;
   logic                 w_set_rd;
   logic [ADDR_SIZE-1:0] w_addr;
   logic [DATA_W-1:0]    w_rdata;

   assign w_cmd = cmd_e'(rx_data[FRAME_W-1:FRAME_W-2]);

   // Command decode; reset gates every action so a frame coinciding with reset is dropped.
   always_comb begin
      w_we     = 1'b0;
      w_re     = 1'b0;
      w_err    = 1'b0;
      w_set_wr = 1'b0;
      w_set_rd = 1'b0;
      if (rx_valid && rst_n) begin
         case (w_cmd)
            CMD_WR_ADDR: w_set_wr = 1'b1;
            CMD_WR_DATA: begin
               w_we  = r_wr_ok;
               w_err = ~r_wr_ok;
            end
            CMD_RD_ADDR: w_set_rd = 1'b1;
            CMD_RD_DATA: begin
               w_re  = r_rd_ok;
               w_err = ~r_rd_ok;
            end
            default: w_err = 1'b1;
         endcase
      end else begin
         w_err = 1'b0;
      end
   end

   assign w_addr = w_re ? r_rd_ptr : r_wr_ptr;

   // Pointers, address-valid flags and one-cycle pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_wr_ok    <= 1'b0;
         r_rd_ok    <= 1'b0;
         r_tx_valid <= 1'b0;
         r_cmd_err  <= 1'b0;
         r_tx_clr   <= 1'b1;
      end else begin
         r_tx_valid <= w_re;
         r_cmd_err  <= w_err;
         if (w_set_wr) begin
            r_wr_ptr <= rx_data[ADDR_SIZE-1:0];
            r_wr_ok  <= 1'b1;
         end
         if (w_we) begin
            r_wr_ptr <= r_wr_ptr + ADDR_SIZE'(1);
         end
         if (w_set_rd) begin
            r_rd_ptr <= rx_data[ADDR_SIZE-1:0];
            r_rd_ok  <= 1'b1;
         end
         if (w_re) begin
            r_rd_ptr <= r_rd_ptr + ADDR_SIZE'(1);
            r_tx_clr <= 1'b0;
         end
      end
   end

   spi_ram_array #(
      .MEM_DEPTH (MEM_DEPTH),
      .ADDR_SIZE (ADDR_SIZE)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_re    (w_re),
      .i_addr  (w_addr),
      .i_wdata (rx_data[DATA_W-1:0]),
      .o_rdata (w_rdata)
   );

   // The RAM read register has no reset, so tx_data reads as zero until the first read after reset.
   assign tx_data  = r_tx_clr ? '0 : w_rdata;
   assign tx_valid = r_tx_valid;
   assign cmd_err  = r_cmd_err;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed self-checking bench for spi_ram_ctrl.
module tb_spi_ram_ctrl;

   logic       clk;
   logic       rst_n;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       cmd_err;

   int checks;
   int errors;

   spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .cmd_err  (cmd_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one frame for one cycle; on return the outputs reflect that frame.
   task automatic step(input logic v, input logic [9:0] f);
      rx_valid = v;
      rx_data  = f;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step(1'b0, 10'h000);
      step(1'b0, 10'h000);
      checks++;
      if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_txd got %h exp %h", tx_data, 8'h00); end
      checks++;
      if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_txv got %b exp %b", tx_valid, 1'b0); end
      checks++;
      if (cmd_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp %b", cmd_err, 1'b0); end
      rst_n = 1'b1;
      step(1'b0, 10'h000);
   endtask

   task automatic test_no_addr();
      step(1'b1, 10'h1AA);
      checks++;
      if (cmd_err !== 1'b1) begin errors++; $display("FAIL noaddr_err got %b exp %b", cmd_err, 1'b1); end
      checks++;
      if (tx_valid !== 1'b0) begin errors++; $display("FAIL noaddr_txv got %b exp %b", tx_valid, 1'b0); end
      step(1'b0, 10'h000);
      checks++;
      if (cmd_err !== 1'b0) begin errors++; $display("FAIL noaddr_err_pulse got %b exp %b", cmd_err, 1'b0); end
   endtask

   task automatic test_single();
      step(1'b1, 10'h012);
      step(1'b1, 10'h155);
      checks++;
      if (cmd_err !== 1'b0) begin errors++; $display("FAIL single_wr_err got %b exp %b", cmd_err, 1'b0); end
      step(1'b0, 10'h000);
      step(1'b1, 10'h212);
      checks++;
      if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_rdaddr_txv got %b exp %b", tx_valid, 1'b0); end
      step(1'b1, 10'h300);
      checks++;
      if (tx_valid !== 1'b1) begin errors++; $display("FAIL single_txv got %b exp %b", tx_valid, 1'b1); end
      checks++;
      if (tx_data !== 8'h55) begin errors++; $display("FAIL single_txd got %h exp %h", tx_data, 8'h55); end
      step(1'b0, 10'h000);
      checks++;
      if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_txv_pulse got %b exp %b", tx_valid, 1'b0); end
      checks++;
      if (tx_data !== 8'h55) begin errors++; $display("FAIL single_txd_hold got %h exp %h", tx_data, 8'h55); end
   endtask

   task automatic test_burst();
      logic [7:0] exp_b [3];
      exp_b[0] = 8'h11;
      exp_b[1] = 8'h22;
      exp_b[2] = 8'h33;
      step(1'b1, 10'h0FE);
      step(1'b1, 10'h111);
      step(1'b1, 10'h122);
      step(1'b1, 10'h133);
      step(1'b1, 10'h2FE);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 10'h300);
         checks++;
         if (tx_valid !== 1'b1) begin errors++; $display("FAIL burst_txv[%0d] got %b exp %b", i, tx_valid, 1'b1); end
         checks++;
         if (tx_data !== exp_b[i]) begin errors++; $display("FAIL burst_txd[%0d] got %h exp %h", i, tx_data, exp_b[i]); end
      end
      step(1'b1, 10'h200);
      step(1'b1, 10'h300);
      checks++;
      if (tx_data !== 8'h33) begin errors++; $display("FAIL burst_wrap_addr0 got %h exp %h", tx_data, 8'h33); end
      step(1'b1, 10'h2FF);
      step(1'b1, 10'h300);
      checks++;
      if (tx_data !== 8'h22) begin errors++; $display("FAIL burst_addrFF got %h exp %h", tx_data, 8'h22); end
      step(1'b0, 10'h000);
   endtask

   task automatic test_back_to_back();
      step(1'b1, 10'h005);
      step(1'b1, 10'h1C3);
      step(1'b1, 10'h205);
      step(1'b1, 10'h3A5);
      checks++;
      if (tx_valid !== 1'b1) begin errors++; $display("FAIL b2b_txv got %b exp %b", tx_valid, 1'b1); end
      checks++;
      if (tx_data !== 8'hC3) begin errors++; $display("FAIL b2b_txd got %h exp %h", tx_data, 8'hC3); end
      step(1'b0, 10'h000);
   endtask

   task automatic test_reset_mid();
      step(1'b1, 10'h205);
      rst_n = 1'b0;
      step(1'b1, 10'h300);
      checks++;
      if (tx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_txv got %b exp %b", tx_valid, 1'b0); end
      checks++;
      if (tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_txd got %h exp %h", tx_data, 8'h00); end
      rst_n = 1'b1;
      step(1'b1, 10'h300);
      checks++;
      if (cmd_err !== 1'b1) begin errors++; $display("FAIL rstmid_rd_err got %b exp %b", cmd_err, 1'b1); end
      checks++;
      if (tx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_rd_txv got %b exp %b", tx_valid, 1'b0); end
      checks++;
      if (tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_rd_txd got %h exp %h", tx_data, 8'h00); end
      step(1'b1, 10'h1AB);
      checks++;
      if (cmd_err !== 1'b1) begin errors++; $display("FAIL rstmid_wr_err got %b exp %b", cmd_err, 1'b1); end
      step(1'b1, 10'h205);
      step(1'b1, 10'h300);
      checks++;
      if (tx_data !== 8'hC3) begin errors++; $display("FAIL rstmid_mem_kept got %h exp %h", tx_data, 8'hC3); end
      step(1'b1, 10'h300);
      checks++;
      if (tx_data === 8'hAB) begin errors++; $display("FAIL rstmid_no_write got %h exp not %h", tx_data, 8'hAB); end
      step(1'b0, 10'h000);
   endtask

   task automatic test_idle();
      step(1'b1, 10'h212);
      step(1'b1, 10'h300);
      step(1'b1, 10'h212);
      step(1'b0, 10'h3FF);
      checks++;
      if (tx_valid !== 1'b0) begin errors++; $display("FAIL idle_txv got %b exp %b", tx_valid, 1'b0); end
      checks++;
      if (cmd_err !== 1'b0) begin errors++; $display("FAIL idle_err got %b exp %b", cmd_err, 1'b0); end
      checks++;
      if (tx_data !== 8'h55) begin errors++; $display("FAIL idle_txd_hold got %h exp %h", tx_data, 8'h55); end
      step(1'b0, 10'h3FF);
      step(1'b0, 10'h155);
      step(1'b1, 10'h300);
      checks++;
      if (tx_data !== 8'h55) begin errors++; $display("FAIL idle_rdptr_kept got %h exp %h", tx_data, 8'h55); end
      step(1'b1, 10'h212);
      step(1'b1, 10'h300);
      checks++;
      if (tx_data !== 8'h55) begin errors++; $display("FAIL idle_no_write got %h exp %h", tx_data, 8'h55); end
      step(1'b0, 10'h000);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 10'h000;
      test_reset();
      test_no_addr();
      test_single();
      test_burst();
      test_back_to_back();
      test_reset_mid();
      test_idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
